// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package if_fetch_unit_pkg;

    localparam int               INSTR_W   = 32;
    localparam logic [31:0]      PC_STEP   = 32'd4;
    localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

    // FETCH: request in flight or issuing; HOLD: word parked behind a freeze;
    // DROP: waiting out a request whose response must be discarded.
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2
    } fetch_state_e;

    // Branch targets are forced word-aligned.
    function automatic logic [31:0] align_word(input logic [31:0] a);
        return a & ~32'd3;
    endfunction

endpackage

// File: rtl/if_fetch_unit_pc_reg.sv
// Program counter register: async reset, redirect beats sequential advance.
module if_pc_reg #(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter logic [31:0] STEP     = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_addr,
    input  logic        advance,
    output logic [31:0] pc
);

    // Load target on redirect, otherwise step on advance; wraps silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pc <= RESET_PC;
        else if (redirect)
            pc <= redirect_addr;
        else if (advance)
            pc <= pc + STEP;
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Fetch stage: owns the PC, talks req/ack to instruction memory and feeds
// pc/instruction into the IF/ID register, honouring freeze and redirects.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter logic [31:0] PC_STEP  = if_fetch_unit_pkg::PC_STEP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] instruction_out
);

    import if_fetch_unit_pkg::*;

    fetch_state_e       state, state_nxt;
    logic [31:0]        fetch_pc;
    logic [INSTR_W-1:0] instr_buf;
    logic [31:0]        tgt;
    logic [31:0]        br_tgt;

    logic               pc_redirect;
    logic [31:0]        pc_redirect_addr;
    logic               pc_advance;
    logic               buf_load;
    logic               tgt_load;

    assign br_tgt    = align_word(branch_addr);
    assign imem_addr = fetch_pc;
    assign pc_out    = fetch_pc + PC_STEP;

    if_pc_reg #(
        .RESET_PC (RESET_PC),
        .STEP     (PC_STEP)
    ) u_pc (
        .clk           (clk),
        .rst           (rst),
        .redirect      (pc_redirect),
        .redirect_addr (pc_redirect_addr),
        .advance       (pc_advance),
        .pc            (fetch_pc)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= FETCH;
        else
            state <= state_nxt;
    end

    // Parked instruction word and pending redirect target.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_buf <= NOP_INSTR;
            tgt       <= '0;
        end else begin
            if (buf_load) instr_buf <= imem_rdata;
            if (tgt_load) tgt       <= br_tgt;
        end
    end

    // Next state, PC control and IF/ID outputs; branch always beats freeze.
    always_comb begin
        state_nxt        = state;
        imem_req         = 1'b1;
        pc_redirect      = 1'b0;
        pc_redirect_addr = br_tgt;
        pc_advance       = 1'b0;
        buf_load         = 1'b0;
        tgt_load         = 1'b0;
        instruction_out  = NOP_INSTR;
        case (state)
            FETCH: begin
                if (branch_taken && imem_ack) begin
                    // Response belongs to the wrong path; drop it.
                    pc_redirect = 1'b1;
                end else if (branch_taken) begin
                    // Address must not move mid-request; remember the target.
                    tgt_load  = 1'b1;
                    state_nxt = DROP;
                end else if (imem_ack && freeze) begin
                    instruction_out = imem_rdata;
                    buf_load        = 1'b1;
                    state_nxt       = HOLD;
                end else if (imem_ack) begin
                    instruction_out = imem_rdata;
                    pc_advance      = 1'b1;
                end
            end
            HOLD: begin
                imem_req = 1'b0;
                if (branch_taken) begin
                    pc_redirect = 1'b1;
                    state_nxt   = FETCH;
                end else begin
                    // Held stable while frozen so IF/ID sees the same word on release.
                    instruction_out = instr_buf;
                    if (!freeze) begin
                        pc_advance = 1'b1;
                        state_nxt  = FETCH;
                    end
                end
            end
            DROP: begin
                if (branch_taken)
                    tgt_load = 1'b1;
                if (imem_ack) begin
                    pc_redirect      = 1'b1;
                    pc_redirect_addr = branch_taken ? br_tgt : tgt;
                    state_nxt        = FETCH;
                end
            end
            default: state_nxt = FETCH;
        endcase
        if (rst)
            instruction_out = NOP_INSTR;
    end

endmodule
